// File: rtl/clkgen_seq_ctrl.sv
// Lane clock-tree sequencer: derives clk4f/clk2f/clk (clk32f /8, /16, /32) from one shared counter
// and gates them on fastest-first, off slowest-first. Define CLKGEN_STATUS_EN to add frame_cnt.
module clkgen_seq_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       en,
    output logic       clk4f,
    output logic       clk2f,
    output logic       clk,
    output logic [2:0] gates,
    output logic       busy,
    output logic       locked
`ifdef CLKGEN_STATUS_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_UP4,
        ST_UP2,
        ST_UP1,
        ST_LOCKED,
        ST_DOWN
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d, state_shed;
    logic [4:0] cnt_q;
    logic [2:0] gates_q, gates_d, gates_shed;
    logic [3:0] settle_q, settle_d;
    logic       clk4f_q, clk2f_q, clk_q, busy_q, locked_q;
    logic       fb;

    assign fb = (cnt_q == 5'd31);

    // Shutdown drops the slowest running domain first; leaving no gate set means OFF.
    always_comb begin
        gates_shed = 3'b000;
        if (gates_q[2]) begin
            gates_shed = {1'b0, gates_q[1:0]};
        end else if (gates_q[1]) begin
            gates_shed = {2'b00, gates_q[0]};
        end
        state_shed = (gates_shed == 3'b000) ? ST_OFF : ST_DOWN;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d  = state_q;
        gates_d  = gates_q;
        settle_d = settle_q;
        if (fb) begin
            unique case (state_q)
                ST_OFF: begin
                    if (en) begin
                        gates_d  = 3'b001;
                        settle_d = '0;
                        state_d  = ST_UP4;
                    end
                end
                ST_UP4, ST_UP2, ST_UP1: begin
                    if (!en) begin
                        gates_d = gates_shed;
                        state_d = state_shed;
                    end else if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        if (state_q == ST_UP4) begin
                            gates_d[1] = 1'b1;
                            state_d    = ST_UP2;
                        end else if (state_q == ST_UP2) begin
                            gates_d[2] = 1'b1;
                            state_d    = ST_UP1;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!en) begin
                        gates_d = gates_shed;
                        state_d = state_shed;
                    end
                end
                ST_DOWN: begin
                    gates_d = gates_shed;
                    state_d = state_shed;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            cnt_q    <= '0;
            state_q  <= ST_OFF;
            gates_q  <= '0;
            settle_q <= '0;
            clk4f_q  <= 1'b0;
            clk2f_q  <= 1'b0;
            clk_q    <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            // NOTE: non-blocking, so the divider taps below see the pre-edge cnt and gates.
            cnt_q    <= cnt_q + 5'd1;
            state_q  <= state_d;
            gates_q  <= gates_d;
            settle_q <= settle_d;
            // Old gates here: a gate set at fb first matters at cnt=0, a cleared one finishes its high phase.
            clk4f_q  <= gates_q[0] & cnt_q[2];
            clk2f_q  <= gates_q[1] & cnt_q[3];
            clk_q    <= gates_q[2] & cnt_q[4];
            busy_q   <= (state_d == ST_UP4) || (state_d == ST_UP2) ||
                        (state_d == ST_UP1) || (state_d == ST_DOWN);
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign clk4f  = clk4f_q;
    assign clk2f  = clk2f_q;
    assign clk    = clk_q;
    assign gates  = gates_q;
    assign busy   = busy_q;
    assign locked = locked_q;

`ifdef CLKGEN_STATUS_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk32f) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (state_q == ST_LOCKED && state_d != ST_LOCKED) begin
            frame_cnt_q <= '0;
        end else if (fb && state_q == ST_LOCKED && frame_cnt_q != 8'hFF) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
